id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 16-bit pipelined core, directly downstream of the fetch stage. It consumes `id_ir` and owns the 8×16 general register file. It produces the EX pipeline register (`ex_ir`, `reg_A`, `reg_B`, `smdr`) with operand forwarding, and it resolves absolute `JUMP` in decode by driving `jp_en`/`jp_addr` back to fetch, squashing the one wrong-path instruction.

## Interface
- No parameters. Opcode constants (`NOP`=5'b00000, `JUMP`, `LOAD`, `STORE`, `LDIH`, `ADDI`, `SUBI`, shifts, `JMPR`, branches) and `exec` come from define.v.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low
- `state`  in  1  pipeline advances only when `state == exec`
- `id_ir`  in  16  instruction from fetch
- `wb_we`, `wb_addr`, `wb_data`  in  1/3/16  register-file write port (WB stage)
- `ex_fwd_we`, `ex_fwd_addr`, `ex_fwd_data`  in  1/3/16  EX-stage result bypass (EX holds `we` low for LOAD)
- `mem_fwd_we`, `mem_fwd_addr`, `mem_fwd_data`  in  1/3/16  MEM-stage result bypass
- `ex_ir`  out  16  instruction to EX
- `reg_A`, `reg_B`  out  16  ALU operands
- `smdr`  out  16  store data for STORE
- `jp_en`  out  1  combinational jump request to fetch
- `jp_addr`  out  8  jump target, `id_ir[7:0]`

## Operation
- Fields: op=[15:11], rd=[10:8], rs1=[6:4], rs2=[2:0], imm4=[3:0], imm8=[7:0].
- Operand A: R[rd] for ADDI/SUBI/LDIH/JMPR/branches; R[rs1] otherwise.
- Operand B rules:
  - ADDI/SUBI/JMPR/branches: {8'h00,imm8}.
  - LDIH: {imm8,8'h00}.
  - LOAD/STORE/shifts: {12'h000,imm4}.
  - All other instructions: R[rs2].
- smdr = R[rd] for STORE, else 0.
- Operand read priority, per operand: EX bypass (we && addr match) > MEM bypass > WB write-through > register file.
- Register file: 8 entries, all writable, reset to 0. A write occurs on a clock edge when `wb_we` && `state == exec`.
- Jump handling:
  - `jp_en = (op == JUMP) && !squash_q && state == exec`.
  - `squash_q` is a register: it is set on an exec edge when `jp_en` = 1 and cleared on the next exec edge.
  - While `squash_q` = 1, the instruction in ID is written to EX as `ex_ir` = 16'h0000 and operands 0.
- JUMP itself goes to EX unchanged (it acts as a NOP there).
- A JUMP sitting in the squashed slot raises no `jp_en`.
- Branch and JMPR shadows are not squashed here; software provides them.

## Timing
- Reset: `ex_ir`, `reg_A`, `reg_B`, `smdr` = 0, `squash_q` = 0, all registers = 0. `jp_en` = 0 because fetch resets `id_ir` to 0.
- Latency: 1 cycle. The instruction in ID at edge n appears on the EX outputs after edge n.
- When `state != exec`, all registers hold. This includes the register file and `squash_q`.
- Jump at fetch address p (in ID during cycle n):
  - Edge n: pc ← target and the slot instruction p+1 enters ID.
  - Edge n+1: p+1 is squashed.
  - The target instruction is in ID at cycle n+2.
- Same-cycle WB write and read of one register: the new value is read (write-through).
- EX and MEM both match the same register: EX wins.
- Load-use with distance 1 is not detected; software inserts one instruction.
- Reset asserted mid-jump clears `squash_q`, so no slot is squashed after reset.

## Configuration
- `ID_FORWARD_EN` defined:
  - EX/MEM bypass muxes are present as specified.
- `ID_FORWARD_EN` undefined:
  - `ex_fwd_*` and `mem_fwd_*` are ignored.
  - Operands come from WB write-through or the register file only.
  - Software must separate a producer and its consumer by 3 instructions.
- WB write-through is present in both builds.

## Test plan
- Reset, then idle.
  - Required: all outputs 0; all registers read 0.
- Writes, then ADD R3,R1,R2.
  - Stimulus: WB writes R1 = 16'h1234, then R2 = 16'h0011; then ADD R3,R1,R2 enters ID.
  - Required: next cycle `reg_A` = 16'h1234, `reg_B` = 16'h0011, `ex_ir` = that ADD.
- Forward priority (build with `ID_FORWARD_EN`).
  - Stimulus: ID reads R1; `ex_fwd` R1 = 16'hAAAA, `mem_fwd` R1 = 16'hBBBB, `wb` R1 = 16'hCCCC.
  - Required: `reg_A` = 16'hAAAA.
  - Drop EX bypass → 16'hBBBB; drop MEM bypass → 16'hCCCC.
- Immediate forms.
  - LDIH R2,8'h5A → `reg_A` = R[2], `reg_B` = 16'h5A00.
  - STORE R4,R1,4'h3 → `reg_A` = R[1], `reg_B` = 16'h0003, `smdr` = R[4].
- JUMP 8'h40 in ID.
  - Required: `jp_en` = 1 and `jp_addr` = 8'h40 in that cycle.
  - Required: the next ID instruction (also a JUMP) gives `ex_ir` = 0 and no `jp_en`.
  - Required: the following instruction passes through normally.
- State hold and mid-jump reset.
  - Stimulus: `state` = idle for 3 cycles with `wb_we` = 1.
  - Required: outputs and registers are unchanged.
  - Stimulus: assert reset while `squash_q` = 1.
  - Required: after release, the first instruction is not squashed.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode: register file, operand select with bypass, and absolute JUMP resolution.
// Latency: 1 cycle from ID to the EX pipeline register. jp_en/jp_addr are combinational.
// Backpressure: nothing moves unless state == exec. Optional macro ID_FORWARD_EN enables the EX/MEM bypass muxes.
module id_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] id_ir,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        ex_fwd_we,
    input  logic [2:0]  ex_fwd_addr,
    input  logic [15:0] ex_fwd_data,
    input  logic        mem_fwd_we,
    input  logic [2:0]  mem_fwd_addr,
    input  logic [15:0] mem_fwd_data,
    output logic [15:0] ex_ir,
    output logic [15:0] reg_A,
    output logic [15:0] reg_B,
    output logic [15:0] smdr,
    output logic        jp_en,
    output logic [7:0]  jp_addr
);

    // Opcode and state encodings shared with the rest of the core
    localparam logic       EXEC  = 1'b1;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] SLL   = 5'b00100;
    localparam logic [4:0] SLA   = 5'b00101;
    localparam logic [4:0] SRL   = 5'b00110;
    localparam logic [4:0] SRA   = 5'b00111;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] LDIH  = 5'b10000;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] JMPR  = 5'b11001;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;
    localparam logic [4:0] BN    = 5'b11100;
    localparam logic [4:0] BNN   = 5'b11101;
    localparam logic [4:0] BC    = 5'b11110;
    localparam logic [4:0] BNC   = 5'b11111;

    logic [15:0] regs [8];
    logic        squash_q;

    logic [4:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [3:0]  imm4;
    logic [7:0]  imm8;
    logic [15:0] a_val, b_val, smdr_val;
    logic [15:0] rd_val, rs1_val, rs2_val;

    assign op   = id_ir[15:11];
    assign rd   = id_ir[10:8];
    assign rs1  = id_ir[6:4];
    assign rs2  = id_ir[2:0];
    assign imm4 = id_ir[3:0];
    assign imm8 = id_ir[7:0];

    assign jp_en   = (op == JUMP) && !squash_q && (state == EXEC);
    assign jp_addr = imm8;

    // Read one register with bypass priority EX > MEM > WB write-through > file
    function automatic logic [15:0] read_reg(input logic [2:0] addr);
        logic [15:0] v;
        v = regs[addr];
        if (wb_we && wb_addr == addr) v = wb_data;
`ifdef ID_FORWARD_EN
        if (mem_fwd_we && mem_fwd_addr == addr) v = mem_fwd_data;
        if (ex_fwd_we && ex_fwd_addr == addr) v = ex_fwd_data;
`endif
        return v;
    endfunction

`ifndef ID_FORWARD_EN
    // Bypass ports exist for pin compatibility but carry nothing in this build
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_we, ex_fwd_addr, ex_fwd_data,
                          mem_fwd_we, mem_fwd_addr, mem_fwd_data};
`endif

    // Operand selection from the decoded opcode
    always_comb begin
        rd_val   = read_reg(rd);
        rs1_val  = read_reg(rs1);
        rs2_val  = read_reg(rs2);
        a_val    = rs1_val;
        b_val    = rs2_val;
        smdr_val = 16'h0000;
        case (op)
            ADDI, SUBI, JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
                a_val = rd_val;
                b_val = {8'h00, imm8};
            end
            LDIH: begin
                a_val = rd_val;
                b_val = {imm8, 8'h00};
            end
            LOAD, SLL, SLA, SRL, SRA: begin
                b_val = {12'h000, imm4};
            end
            STORE: begin
                b_val    = {12'h000, imm4};
                smdr_val = rd_val;
            end
            default: ;
        endcase
    end

    // Register file, squash flag and EX pipeline register; all hold outside exec
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
            squash_q <= 1'b0;
            ex_ir    <= 16'h0000;
            reg_A    <= 16'h0000;
            reg_B    <= 16'h0000;
            smdr     <= 16'h0000;
        end else if (state == EXEC) begin
            if (wb_we) regs[wb_addr] <= wb_data;
            // jp_en is already gated by squash_q, so this also clears the flag
            squash_q <= jp_en;
            if (squash_q) begin
                ex_ir <= 16'h0000;
                reg_A <= 16'h0000;
                reg_B <= 16'h0000;
                smdr  <= 16'h0000;
            end else begin
                ex_ir <= id_ir;
                reg_A <= a_val;
                reg_B <= b_val;
                smdr  <= smdr_val;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, register reads, bypass priority, immediates, jump squash, hold, reset mid-jump.
// Outputs sampled 1 time unit after the rising edge; inputs driven there too.
// Bypass expectations follow whether ID_FORWARD_EN is defined for the build.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] id_ir;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_fwd_we;
    logic [2:0]  ex_fwd_addr;
    logic [15:0] ex_fwd_data;
    logic        mem_fwd_we;
    logic [2:0]  mem_fwd_addr;
    logic [15:0] mem_fwd_data;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic        jp_en;
    logic [7:0]  jp_addr;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] ADD_R3_R1_R2 = {5'b01000, 3'd3, 1'b0, 3'd1, 1'b0, 3'd2};
    localparam logic [15:0] ADD_R5_R1_R2 = {5'b01000, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2};
    localparam logic [15:0] LDIH_R2_5A   = {5'b10000, 3'd2, 8'h5A};
    localparam logic [15:0] STORE_R4_R1  = {5'b00011, 3'd4, 1'b0, 3'd1, 4'h3};
    localparam logic [15:0] JUMP_40      = {5'b11000, 3'd0, 8'h40};
    localparam logic [15:0] JUMP_80      = {5'b11000, 3'd0, 8'h80};

    id_stage dut (
        .clock(clock), .reset(reset), .state(state), .id_ir(id_ir),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr),
        .jp_en(jp_en), .jp_addr(jp_addr)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] fwd_a;

        reset = 1'b0; state = 1'b1; id_ir = 16'h0000;
        wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
        ex_fwd_we = 1'b0; ex_fwd_addr = 3'd0; ex_fwd_data = 16'h0000;
        mem_fwd_we = 1'b0; mem_fwd_addr = 3'd0; mem_fwd_data = 16'h0000;
        step(); step();

        // Reset state
        chk("rst_ex_ir", ex_ir, 16'h0000);
        chk("rst_reg_A", reg_A, 16'h0000);
        chk("rst_reg_B", reg_B, 16'h0000);
        chk("rst_smdr",  smdr,  16'h0000);
        chk("rst_jp_en", {15'b0, jp_en}, 16'h0000);
        reset = 1'b1;
        step();

        // Every register reads 0 after reset
        for (int i = 0; i < 8; i++) begin
            id_ir = {5'b01000, 3'd0, 1'b0, i[2:0], 1'b0, i[2:0]};
            step();
            chk($sformatf("idle_rA_r%0d", i), reg_A, 16'h0000);
            chk($sformatf("idle_rB_r%0d", i), reg_B, 16'h0000);
        end

        // Register writes then ADD R3,R1,R2
        id_ir = 16'h0000;
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
        step();
        wb_addr = 3'd2; wb_data = 16'h0011;
        step();
        wb_we = 1'b0;
        id_ir = ADD_R3_R1_R2;
        step();
        chk("add_ex_ir", ex_ir, ADD_R3_R1_R2);
        chk("add_reg_A", reg_A, 16'h1234);
        chk("add_reg_B", reg_B, 16'h0011);
        chk("add_smdr",  smdr,  16'h0000);

        // Bypass priority on R1: EX > MEM > WB write-through
        id_ir = ADD_R5_R1_R2;
        ex_fwd_we = 1'b1;  ex_fwd_addr = 3'd1;  ex_fwd_data = 16'hAAAA;
        mem_fwd_we = 1'b1; mem_fwd_addr = 3'd1; mem_fwd_data = 16'hBBBB;
        wb_we = 1'b1;      wb_addr = 3'd1;      wb_data = 16'hCCCC;
`ifdef ID_FORWARD_EN
        fwd_a = 16'hAAAA;
`else
        fwd_a = 16'hCCCC;
`endif
        step();
        chk("fwd_ex_wins", reg_A, fwd_a);
        chk("fwd_rB_r2",   reg_B, 16'h0011);
        ex_fwd_we = 1'b0;
`ifdef ID_FORWARD_EN
        fwd_a = 16'hBBBB;
`else
        fwd_a = 16'hCCCC;
`endif
        step();
        chk("fwd_mem_wins", reg_A, fwd_a);
        mem_fwd_we = 1'b0;
        step();
        chk("fwd_wb_thru", reg_A, 16'hCCCC);

        // Immediate forms; R4 = BEEF for store data
        wb_addr = 3'd4; wb_data = 16'hBEEF;
        id_ir = LDIH_R2_5A;
        step();
        wb_we = 1'b0;
        chk("ldih_reg_A", reg_A, 16'h0011);
        chk("ldih_reg_B", reg_B, 16'h5A00);
        chk("ldih_smdr",  smdr,  16'h0000);
        id_ir = STORE_R4_R1;
        step();
        chk("st_reg_A", reg_A, 16'hCCCC);
        chk("st_reg_B", reg_B, 16'h0003);
        chk("st_smdr",  smdr,  16'hBEEF);

        // JUMP, squashed JUMP in the slot, then normal flow
        id_ir = JUMP_40;
        #1;
        chk("jmp_jp_en",   {15'b0, jp_en}, 16'h0001);
        chk("jmp_jp_addr", {8'h00, jp_addr}, 16'h0040);
        step();
        chk("jmp_ex_ir", ex_ir, JUMP_40);
        id_ir = JUMP_80;
        #1;
        chk("slot_jp_en", {15'b0, jp_en}, 16'h0000);
        step();
        chk("slot_ex_ir", ex_ir, 16'h0000);
        chk("slot_reg_A", reg_A, 16'h0000);
        chk("slot_reg_B", reg_B, 16'h0000);
        id_ir = ADD_R3_R1_R2;
        #1;
        chk("post_jp_en", {15'b0, jp_en}, 16'h0000);
        step();
        chk("post_ex_ir", ex_ir, ADD_R3_R1_R2);
        chk("post_reg_A", reg_A, 16'hCCCC);

        // Idle for 3 cycles with a WB write pending: everything holds
        state = 1'b0;
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h5555;
        id_ir = STORE_R4_R1;
        #1;
        chk("idle_jp_en", {15'b0, jp_en}, 16'h0000);
        step(); step(); step();
        chk("hold_ex_ir", ex_ir, ADD_R3_R1_R2);
        chk("hold_reg_A", reg_A, 16'hCCCC);
        chk("hold_reg_B", reg_B, 16'h0011);
        chk("hold_smdr",  smdr,  16'h0000);
        state = 1'b1; wb_we = 1'b0;
        id_ir = ADD_R3_R1_R2;
        step();
        chk("hold_rf_r1", reg_A, 16'hCCCC);

        // Reset while squash_q is set: first instruction after release is not squashed
        id_ir = JUMP_40;
        step();
        reset = 1'b0;
        #2;
        chk("mrst_ex_ir", ex_ir, 16'h0000);
        reset = 1'b1;
        id_ir = ADD_R3_R1_R2;
        step();
        chk("mrst_ex_ir_pass", ex_ir, ADD_R3_R1_R2);
        chk("mrst_reg_A",      reg_A, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
